// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the 8N1 serial receive path
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned CLKS_PER_BIT_DEF = 16;
   localparam int unsigned DATA_W           = 8;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with a parameterised reset value
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 receive deserializer with bit-centre sampling and tick strobe
// Define UART_TX_SYNC_EN to place a two-flop synchronizer on rxd (adds 2 cycles of latency).
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rxd,
   output logic [DATA_W-1:0] data_out,
   output logic              rx_done,
   output logic              tick
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic rxd_s;

`ifdef UART_TX_SYNC_EN
   uart_sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk_i  (clk),
      .rst_ni (rst),
      .d_i    (rxd),
      .q_o    (rxd_s)
   );
`else
   assign rxd_s = rxd;
`endif

   uart_state_e       state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        bit_idx_q;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] data_q;
   logic              rx_done_q;
   logic              tick_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         rx_done_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         tick_q    <= 1'b0;
         rx_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (!rxd_s) begin
                  state_q <= START;
               end
            end
            START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q <= '0;
                  // A line that is high again at the start-bit centre was only a glitch.
                  if (!rxd_s) begin
                     tick_q    <= 1'b1;
                     bit_idx_q <= '0;
                     state_q   <= DATA;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            DATA: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q              <= '0;
                  tick_q             <= 1'b1;
                  shift_q[bit_idx_q] <= rxd_s;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            STOP: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  tick_q  <= 1'b1;
                  state_q <= IDLE;
                  if (rxd_s) begin
                     data_q    <= shift_q;
                     rx_done_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign data_out = data_q;
   assign rx_done  = rx_done_q;
   assign tick     = tick_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (frame-level timing and data model)
module tb_uart_tx;

   localparam int C = 16;
`ifdef UART_TX_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic [7:0] data_out;
   logic       rx_done;
   logic       tick;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int         tick_q[$];
   int         done_q[$];
   logic [7:0] done_data[$];

   typedef struct {
      logic [7:0] d;
      bit         stop;
      int         gap_after;
      logic [7:0] exp_data;
      bit         exp_done;
   } vec_t;

   vec_t vecs[$];

   always #10 clk = ~clk;

   uart_tx #(
      .CLKS_PER_BIT (C)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rxd      (rxd),
      .data_out (data_out),
      .rx_done  (rx_done),
      .tick     (tick)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tick) tick_q.push_back(cyc);
      if (rx_done) begin
         done_q.push_back(cyc);
         done_data.push_back(data_out);
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Line is driven at negedges; the first posedge that sees the start bit is p0.
   task automatic send_frame(input logic [7:0] d, input bit stop, output int p0);
      p0  = cyc + 1;
      rxd = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         repeat (C) @(negedge clk);
      end
      rxd = stop;
      repeat (C) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic check_quiet(input string nm, input int lo, input int hi);
      int nt = 0;
      int nd = 0;
      foreach (tick_q[i]) if (tick_q[i] >= lo && tick_q[i] < hi) nt++;
      foreach (done_q[i]) if (done_q[i] >= lo && done_q[i] < hi) nd++;
      check({nm, " ticks"}, nt, 0);
      check({nm, " rx_done"}, nd, 0);
   endtask

   task automatic check_frame(input string nm, input int p0, input logic [7:0] exp_data,
                              input bit exp_done, output int done_cyc);
      int         w[$];
      int         dn[$];
      logic [7:0] dd[$];
      int         hi = p0 + 10 * C - 1;
      foreach (tick_q[i]) if (tick_q[i] >= p0 && tick_q[i] < hi) w.push_back(tick_q[i]);
      foreach (done_q[i]) begin
         if (done_q[i] >= p0 && done_q[i] < hi) begin
            dn.push_back(done_q[i]);
            dd.push_back(done_data[i]);
         end
      end
      check({nm, " tick count"}, w.size(), 10);
      for (int k = 0; k < w.size() && k < 10; k++)
         check($sformatf("%s tick%0d cycle", nm, k), w[k], p0 + LAT + C / 2 + k * C);
      check({nm, " rx_done count"}, dn.size(), int'(exp_done));
      if (dn.size() > 0) begin
         check({nm, " rx_done cycle"}, dn[0], p0 + LAT + C / 2 + 9 * C);
         check({nm, " data at rx_done"}, dd[0], exp_data);
      end
      check({nm, " data_out"}, data_out, exp_data);
      done_cyc = (dn.size() > 0) ? dn[0] : -1;
   endtask

   initial begin
      int         p0;
      int         dc;
      int         prev_dc;
      int         lo;
      bit         prev_b2b;
      logic [7:0] model_data;
      vec_t       v;

      rst = 1'b0;
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      check("reset data_out", data_out, 8'h00);
      check("reset tick", tick, 0);
      check("reset rx_done", rx_done, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      lo  = cyc + 1;
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * C) @(negedge clk);
      check_quiet("false start", lo, cyc);
      check("false start data_out", data_out, 8'h00);

      vecs.push_back('{8'hB5, 1'b1, 0,     8'hB5, 1'b1});
      vecs.push_back('{8'h00, 1'b1, 0,     8'h00, 1'b1});
      vecs.push_back('{8'hFF, 1'b1, 0,     8'hFF, 1'b1});
      vecs.push_back('{8'h5A, 1'b1, 0,     8'h5A, 1'b1});
      vecs.push_back('{8'h3C, 1'b0, 2 * C, 8'h5A, 1'b0});
      model_data = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         v.d         = 8'($urandom);
         v.stop      = ($urandom_range(0, 3) != 0);
         v.gap_after = v.stop ? int'($urandom_range(0, C)) : 2 * C;
         if (v.stop) model_data = v.d;
         v.exp_data  = model_data;
         v.exp_done  = v.stop;
         vecs.push_back(v);
      end

      prev_dc  = -1;
      prev_b2b = 1'b0;
      foreach (vecs[i]) begin
         send_frame(vecs[i].d, vecs[i].stop, p0);
         check_frame($sformatf("frame%0d(%02h)", i, vecs[i].d), p0, vecs[i].exp_data,
                     vecs[i].exp_done, dc);
         if (prev_b2b && prev_dc >= 0 && dc >= 0)
            check($sformatf("frame%0d rx_done spacing", i), dc - prev_dc, 10 * C);
         if (vecs[i].gap_after > 0) begin
            lo = cyc;
            repeat (vecs[i].gap_after) @(negedge clk);
            check_quiet($sformatf("gap after frame%0d", i), lo, cyc);
         end
         prev_dc  = dc;
         prev_b2b = (vecs[i].gap_after == 0);
      end
      model_data = vecs[vecs.size() - 1].exp_data;

      rxd = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd = (8'hA5 >> i) & 8'h01;
         repeat (C) @(negedge clk);
      end
      rxd = 1'b0;
      repeat (C / 2) @(negedge clk);
      #3 rst = 1'b0;
      #1;
      check("mid-frame reset data_out", data_out, 8'h00);
      check("mid-frame reset tick", tick, 0);
      check("mid-frame reset rx_done", rx_done, 0);
      rxd = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (C) @(negedge clk);

      send_frame(8'h81, 1'b1, p0);
      check_frame("post-reset 81", p0, 8'h81, 1'b1, dc);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
